// File: rtl/result_writeback_if.sv
// Stream bundle for result_writeback: config words, result beats,
// S2MM command, packed S2MM data and S2MM status.
// The "master" modport is the writeback block's view; "slave" is the
// view of the surrounding system (array output, DataMover, control).
interface result_writeback_if;
    logic         s_axis_wbconfig_tvalid;
    logic         s_axis_wbconfig_tready;
    logic [31:0]  s_axis_wbconfig_tdata;

    logic         s_axis_res_tvalid;
    logic         s_axis_res_tready;
    logic [63:0]  s_axis_res_tdata;

    logic         m_axis_s2mm_cmd_tvalid;
    logic         m_axis_s2mm_cmd_tready;
    logic [71:0]  m_axis_s2mm_cmd_tdata;

    logic         m_axis_s2mm_tvalid;
    logic         m_axis_s2mm_tready;
    logic [127:0] m_axis_s2mm_tdata;
    logic [15:0]  m_axis_s2mm_tkeep;
    logic         m_axis_s2mm_tlast;

    logic         s_axis_s2mm_sts_tvalid;
    logic         s_axis_s2mm_sts_tready;
    logic [7:0]   s_axis_s2mm_sts_tdata;

    modport master (
        input  s_axis_wbconfig_tvalid, s_axis_wbconfig_tdata,
        output s_axis_wbconfig_tready,
        input  s_axis_res_tvalid, s_axis_res_tdata,
        output s_axis_res_tready,
        output m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tdata,
        input  m_axis_s2mm_cmd_tready,
        output m_axis_s2mm_tvalid, m_axis_s2mm_tdata, m_axis_s2mm_tkeep, m_axis_s2mm_tlast,
        input  m_axis_s2mm_tready,
        input  s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tdata,
        output s_axis_s2mm_sts_tready
    );

    modport slave (
        output s_axis_wbconfig_tvalid, s_axis_wbconfig_tdata,
        input  s_axis_wbconfig_tready,
        output s_axis_res_tvalid, s_axis_res_tdata,
        input  s_axis_res_tready,
        input  m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tdata,
        output m_axis_s2mm_cmd_tready,
        input  m_axis_s2mm_tvalid, m_axis_s2mm_tdata, m_axis_s2mm_tkeep, m_axis_s2mm_tlast,
        output m_axis_s2mm_tready,
        output s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tdata,
        input  s_axis_s2mm_sts_tready
    );
endinterface

// File: rtl/result_writeback.sv
// result_writeback: packs 64-bit result beats into 128-bit words and writes
// them to DDR through DataMover S2MM, splitting jobs into CHUNK_BYTES commands.
// Optional macro WB_TAG_CHECK_EN: per-command incrementing tag, checked
// against the returned status tag.
module result_writeback #(
    parameter int unsigned CHUNK_BYTES = 4194304,
    parameter int unsigned CFG_WORDS   = 2
) (
    input  logic                clk,
    input  logic                rst,
    result_writeback_if.master  wb,
    output logic                wb_done,
    output logic                wb_error,
    output logic [3:0]          status_wb
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_STS  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam int          CFG_CNT_W = $clog2(CFG_WORDS + 1);
    localparam int          BEATS_W   = 19;
    localparam logic [31:0] CHUNK_MAX = 32'(CHUNK_BYTES);

    state_t               state_q, state_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic [CFG_CNT_W-1:0] cfg_cnt_q, cfg_cnt_d;
    logic [31:0]          cur_addr_q, cur_addr_d;
    logic [31:0]          remaining_q, remaining_d;
    logic [BEATS_W-1:0]   chunk_beats_q, chunk_beats_d;
    logic [BEATS_W-1:0]   packed_cnt_q, packed_cnt_d;
    logic [BEATS_W-1:0]   out_cnt_q, out_cnt_d;
    logic                 pack_half_q, pack_half_d;
    logic [63:0]          low_q, low_d;
    logic [127:0]         out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sts_held_q, sts_held_d;
    logic [7:0]           sts_data_q, sts_data_d;

    logic [31:0] chunk;
    logic [31:0] btt_word;
    logic        bad_btt, last_cfg;
    logic        cfg_hs, res_ready, res_hs, out_hs, cmd_hs, last_out;
    logic        sts_in, sts_pending, sts_err, tag_bad;
    logic [7:0]  sts_word;
    logic [3:0]  cmd_tag;

`ifdef WB_TAG_CHECK_EN
    logic [3:0] tag_q, tag_d;
    logic [3:0] sent_tag_q, sent_tag_d;
    assign cmd_tag = tag_q;
    assign tag_bad = (sts_word[3:0] != sent_tag_q);
`else
    logic unused_sts_tag;
    assign cmd_tag        = 4'h0;
    assign tag_bad        = 1'b0;
    assign unused_sts_tag = ^sts_word[3:0];
`endif

    assign chunk       = (remaining_q < CHUNK_MAX) ? remaining_q : CHUNK_MAX;
    assign last_cfg    = (cfg_cnt_q == CFG_CNT_W'(CFG_WORDS - 1));
    assign btt_word    = (cfg_cnt_q == CFG_CNT_W'(1)) ? wb.s_axis_wbconfig_tdata : remaining_q;
    assign bad_btt     = (btt_word == 32'd0) || (btt_word[3:0] != 4'd0);
    assign cfg_hs      = wb.s_axis_wbconfig_tvalid & cfg_ready_q;
    assign res_ready   = (state_q == ST_DATA) && (packed_cnt_q < chunk_beats_q) &&
                         (!pack_half_q || !out_valid_q || wb.m_axis_s2mm_tready);
    assign res_hs      = wb.s_axis_res_tvalid & res_ready;
    assign out_hs      = out_valid_q & wb.m_axis_s2mm_tready;
    assign last_out    = out_valid_q && (out_cnt_q == chunk_beats_q - BEATS_W'(1));
    assign cmd_hs      = (state_q == ST_CMD) & wb.m_axis_s2mm_cmd_tready;
    assign sts_in      = wb.s_axis_s2mm_sts_tvalid;
    assign sts_pending = sts_held_q | sts_in;
    assign sts_word    = sts_held_q ? sts_data_q : wb.s_axis_s2mm_sts_tdata;
    assign sts_err     = ~sts_word[7] | (|sts_word[6:4]) | tag_bad;

    assign wb.s_axis_wbconfig_tready = cfg_ready_q;
    assign wb.s_axis_res_tready      = res_ready;
    assign wb.m_axis_s2mm_cmd_tvalid = (state_q == ST_CMD);
    assign wb.m_axis_s2mm_cmd_tdata  = {4'h0, cmd_tag, cur_addr_q, 1'b0, 1'b1, 6'h00, 1'b1, chunk[22:0]};
    assign wb.m_axis_s2mm_tvalid     = out_valid_q;
    assign wb.m_axis_s2mm_tdata      = out_data_q;
    assign wb.m_axis_s2mm_tkeep      = 16'hffff;
    assign wb.m_axis_s2mm_tlast      = last_out;
    assign wb.s_axis_s2mm_sts_tready = 1'b1;
    assign wb_done                   = (state_q == ST_DONE);
    assign wb_error                  = (state_q == ST_ERR);
    assign status_wb                 = {1'b0, state_q};

    // Next-state logic: config intake, command issue, pair packing, status check
    always_comb begin
        state_d       = state_q;
        cfg_ready_d   = cfg_ready_q;
        cfg_cnt_d     = cfg_cnt_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        chunk_beats_d = chunk_beats_q;
        packed_cnt_d  = packed_cnt_q;
        out_cnt_d     = out_cnt_q;
        pack_half_d   = pack_half_q;
        low_d         = low_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        sts_held_d    = sts_held_q;
        sts_data_d    = sts_data_q;
`ifdef WB_TAG_CHECK_EN
        tag_d         = tag_q;
        sent_tag_d    = sent_tag_q;
`endif

        if (out_hs) begin
            out_valid_d = 1'b0;
            out_cnt_d   = out_cnt_q + BEATS_W'(1);
        end
        if (res_hs) begin
            if (!pack_half_q) begin
                low_d       = wb.s_axis_res_tdata;
                pack_half_d = 1'b1;
            end else begin
                out_data_d   = {wb.s_axis_res_tdata, low_q};
                out_valid_d  = 1'b1;
                pack_half_d  = 1'b0;
                packed_cnt_d = packed_cnt_q + BEATS_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                sts_held_d  = 1'b0;
                cfg_ready_d = 1'b1;
                if (cfg_hs) begin
                    if (cfg_cnt_q == CFG_CNT_W'(0)) cur_addr_d  = wb.s_axis_wbconfig_tdata;
                    if (cfg_cnt_q == CFG_CNT_W'(1)) remaining_d = wb.s_axis_wbconfig_tdata;
                    if (last_cfg) begin
                        cfg_ready_d  = 1'b0;
                        cfg_cnt_d    = '0;
                        out_cnt_d    = '0;
                        packed_cnt_d = '0;
                        pack_half_d  = 1'b0;
`ifdef WB_TAG_CHECK_EN
                        tag_d        = 4'h0;
`endif
                        state_d      = bad_btt ? ST_ERR : ST_CMD;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q + CFG_CNT_W'(1);
                    end
                end
            end
            ST_CMD: begin
                if (sts_in && !sts_held_q) begin
                    sts_held_d = 1'b1;
                    sts_data_d = wb.s_axis_s2mm_sts_tdata;
                end
                if (cmd_hs) begin
                    cur_addr_d    = cur_addr_q + chunk;
                    remaining_d   = remaining_q - chunk;
                    chunk_beats_d = chunk[22:4];
`ifdef WB_TAG_CHECK_EN
                    sent_tag_d    = tag_q;
                    tag_d         = tag_q + 4'h1;
`endif
                    state_d       = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sts_in && !sts_held_q) begin
                    sts_held_d = 1'b1;
                    sts_data_d = wb.s_axis_s2mm_sts_tdata;
                end
                if (out_hs && last_out) state_d = ST_STS;
            end
            ST_STS: begin
                if (sts_pending) begin
                    sts_held_d = sts_held_q & sts_in;
                    if (sts_held_q && sts_in) sts_data_d = wb.s_axis_s2mm_sts_tdata;
                    if (sts_err) begin
                        state_d = ST_ERR;
                    end else if (remaining_q == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        out_cnt_d    = '0;
                        packed_cnt_d = '0;
                        state_d      = ST_CMD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // State and datapath registers; reset discards any half-packed pair
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cfg_ready_q   <= 1'b0;
            cfg_cnt_q     <= '0;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            chunk_beats_q <= '0;
            packed_cnt_q  <= '0;
            out_cnt_q     <= '0;
            pack_half_q   <= 1'b0;
            low_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            sts_held_q    <= 1'b0;
            sts_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cfg_ready_q   <= cfg_ready_d;
            cfg_cnt_q     <= cfg_cnt_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            chunk_beats_q <= chunk_beats_d;
            packed_cnt_q  <= packed_cnt_d;
            out_cnt_q     <= out_cnt_d;
            pack_half_q   <= pack_half_d;
            low_q         <= low_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            sts_held_q    <= sts_held_d;
            sts_data_q    <= sts_data_d;
        end
    end

`ifdef WB_TAG_CHECK_EN
    // Tag of the next command and of the command awaiting status
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= 4'h0;
            sent_tag_q <= 4'h0;
        end else begin
            tag_q      <= tag_d;
            sent_tag_q <= sent_tag_d;
        end
    end
`endif
endmodule
